// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 window generator for the Sobel gradient stages.
// Two line buffers hold the previous two image rows. A 3x3 shift window is fed
// from the line-buffer outputs and the incoming pixel. The window is flagged
// only when all nine taps belong to the current frame and the current row.
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valid,
  input  logic          sof,
  output logic [7:0]    P0,
  output logic [7:0]    P1,
  output logic [7:0]    P2,
  output logic [7:0]    P3,
  output logic [7:0]    P4,
  output logic [7:0]    P5,
  output logic [7:0]    P6,
  output logic [7:0]    P7,
  output logic [7:0]    P8,
  output logic          start_calculations,
  output logic [RW-1:0] center_row,
  output logic [CW-1:0] center_col,
  output logic          frame_done
);

  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Line buffers: lb1 holds row r-1, lb0 holds row r-2, both indexed by column.
  logic [7:0] lb0_mem [0:IMG_WIDTH-1];
  logic [7:0] lb1_mem [0:IMG_WIDTH-1];

  logic [RW-1:0] row_q, row_d, cur_row_s;
  logic [CW-1:0] col_q, col_d, cur_col_s;
  logic [7:0]    win_q [0:8];
  logic [7:0]    win_d [0:8];
  logic          start_q, start_d;
  logic          frame_done_q, frame_done_d;
  logic [RW-1:0] center_row_q, center_row_d;
  logic [CW-1:0] center_col_q, center_col_d;
  logic [7:0]    top_s, mid_s;

  // Position of the pixel on the input: sof forces (0,0) over the counters.
  always_comb begin
    cur_row_s = row_q;
    cur_col_s = col_q;
    if (sof) begin
      cur_row_s = ROW_ZERO;
      cur_col_s = COL_ZERO;
    end else begin
      cur_row_s = row_q;
      cur_col_s = col_q;
    end
  end

  assign top_s = lb0_mem[cur_col_s];
  assign mid_s = lb1_mem[cur_col_s];

  // Next-state: counter advance, window shift, strobes and centre coordinates.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    win_d        = win_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    center_row_d = center_row_q;
    center_col_d = center_col_q;
    if (pixel_valid) begin
      if (cur_col_s == COL_LAST) begin
        col_d = COL_ZERO;
        if (cur_row_s == ROW_LAST) begin
          row_d = ROW_ZERO;
        end else begin
          row_d = cur_row_s + ROW_ONE;
        end
      end else begin
        col_d = cur_col_s + COL_ONE;
        row_d = cur_row_s;
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_s;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_s;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;
      // Rows 0-1 and columns 0-1 would mix stale or wrapped taps.
      if ((cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO)) begin
        start_d      = 1'b1;
        center_row_d = cur_row_s - ROW_ONE;
        center_col_d = cur_col_s - COL_ONE;
      end else begin
        start_d = 1'b0;
      end
      // A sof pixel is (0,0) and can never be the last pixel.
      frame_done_d = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    end else begin
      start_d      = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      row_q        <= ROW_ZERO;
      col_q        <= COL_ZERO;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      center_row_q <= ROW_ZERO;
      center_col_q <= COL_ZERO;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= 8'h00;
      end
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      center_row_q <= center_row_d;
      center_col_q <= center_col_d;
      win_q        <= win_d;
    end
  end

  // Line-buffer update on accept; contents are not reset, reset blocks the write.
  always_ff @(posedge clk) begin
    if (n_rst && pixel_valid) begin
      lb0_mem[cur_col_s] <= mid_s;
      lb1_mem[cur_col_s] <= pixel_in;
    end
  end

  assign P0 = win_q[0];
  assign P1 = win_q[1];
  assign P2 = win_q[2];
  assign P3 = win_q[3];
  assign P4 = win_q[4];
  assign P5 = win_q[5];
  assign P6 = win_q[6];
  assign P7 = win_q[7];
  assign P8 = win_q[8];
  assign start_calculations = start_q;
  assign frame_done         = frame_done_q;
  assign center_row         = center_row_q;
  assign center_col         = center_col_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Self-checking bench for sobel_window_buffer on a 4x4 image.
// A frame-image model predicts each window from the pixels stored at their
// (row, col) positions; one negedge process compares it against the DUT.
module tb_sobel_window_buffer;

  localparam int TW = 4;
  localparam int TH = 4;
  localparam logic [71:0] W_FIRST = 72'h00_01_02_10_11_12_20_21_22;
  localparam logic [71:0] W_LAST  = 72'h11_12_13_21_22_23_31_32_33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, pixel_valid, sof;
  logic [7:0] pixel_in;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic       start_calculations, frame_done;
  logic [1:0] center_row, center_col;

  sobel_window_buffer #(.IMG_WIDTH(TW), .IMG_HEIGHT(TH)) dut (
    .clk(clk), .n_rst(n_rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
    .start_calculations(start_calculations), .center_row(center_row),
    .center_col(center_col), .frame_done(frame_done)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: pixels are stored by frame position; windows are read from that image.
  logic [7:0] img [0:TH-1][0:TW-1];
  int         mrow = 0, mcol = 0, m_r, m_c;
  logic       armed = 1'b0, win_known = 1'b0;
  logic       exp_start = 1'b0, exp_fd = 1'b0;
  logic [1:0] exp_crow = 2'd0, exp_ccol = 2'd0;
  logic [7:0] exp_win [0:8];

  always_comb begin
    m_r = sof ? 0 : mrow;
    m_c = sof ? 0 : mcol;
  end

  always @(posedge clk) begin
    if (!n_rst) begin
      armed     <= 1'b1;
      mrow      <= 0;
      mcol      <= 0;
      exp_start <= 1'b0;
      exp_fd    <= 1'b0;
      exp_crow  <= 2'd0;
      exp_ccol  <= 2'd0;
      win_known <= 1'b1;
      for (int k = 0; k < 9; k++) exp_win[k] <= 8'h00;
    end else if (pixel_valid) begin
      img[m_r][m_c] <= pixel_in;
      exp_fd <= (m_r == TH-1) && (m_c == TW-1);
      if (m_c == TW-1) begin
        mcol <= 0;
        mrow <= (m_r == TH-1) ? 0 : m_r + 1;
      end else begin
        mcol <= m_c + 1;
        mrow <= m_r;
      end
      if (m_r >= 2 && m_c >= 2) begin
        exp_start <= 1'b1;
        win_known <= 1'b1;
        exp_crow  <= 2'(m_r - 1);
        exp_ccol  <= 2'(m_c - 1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[3*i+j] <= (i == 2 && j == 2) ? pixel_in : img[m_r-2+i][m_c-2+j];
      end else begin
        exp_start <= 1'b0;
        win_known <= 1'b0;
      end
    end else begin
      exp_start <= 1'b0;
      exp_fd    <= 1'b0;
    end
  end

  // Requests from the stimulus for literal / count checks, consumed by the compare process.
  int req_seq = 0, seen_seq = 0, req_id = 0, req_n = 0, req_f = 0;
  int strobe_cnt = 0, fd_cnt = 0, base_s = 0, base_f = 0;

  logic [71:0] dut_pack, exp_pack;
  assign dut_pack = {P0, P1, P2, P3, P4, P5, P6, P7, P8};
  assign exp_pack = {exp_win[0], exp_win[1], exp_win[2], exp_win[3], exp_win[4],
                     exp_win[5], exp_win[6], exp_win[7], exp_win[8]};

  // Compare process: every cycle after the first reset, plus requested checks.
  always @(negedge clk) begin
    if (armed) begin
      chk("start_calculations", 72'(start_calculations), 72'(exp_start));
      chk("frame_done", 72'(frame_done), 72'(exp_fd));
      chk("center_row", 72'(center_row), 72'(exp_crow));
      chk("center_col", 72'(center_col), 72'(exp_ccol));
      if (win_known) chk("window", dut_pack, exp_pack);
      if (start_calculations === 1'b1) strobe_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (req_seq != seen_seq) begin
        seen_seq = req_seq;
        case (req_id)
          1: begin
            chk("first_window_dut", dut_pack, W_FIRST);
            chk("first_window_model", exp_pack, W_FIRST);
            chk("first_window_strobe", 72'(start_calculations), 72'd1);
            chk("first_window_center", 72'({center_row, center_col}), 72'h5);
          end
          2: begin
            chk("last_window_dut", dut_pack, W_LAST);
            chk("last_window_model", exp_pack, W_LAST);
            chk("last_window_frame_done", 72'(frame_done), 72'd1);
            chk("last_window_center", 72'({center_row, center_col}), 72'hA);
          end
          3: begin
            base_s = strobe_cnt;
            base_f = fd_cnt;
          end
          4: begin
            chk("strobe_count", 72'(strobe_cnt - base_s), 72'(req_n));
            chk("frame_done_count", 72'(fd_cnt - base_f), 72'(req_f));
          end
          5: begin
            chk("reset_window", dut_pack, 72'd0);
            chk("reset_strobes", 72'({start_calculations, frame_done}), 72'd0);
            chk("reset_center", 72'({center_row, center_col}), 72'd0);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic req(input int id);
    req_id = id;
    req_seq++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      pixel_valid = 1'b0;
      sof = 1'b0;
    end
  endtask

  task automatic put(input int r, input int c, input bit s, input bit gaps);
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) idle(1);
    @(negedge clk); #1;
    pixel_valid = 1'b1;
    sof = s;
    pixel_in = 8'(16*r + c);
    if (r == 2 && c == 2) req(1);
    if (r == 3 && c == 3) req(2);
  endtask

  // Feed a frame of 16*row+col pixels, stopping before (stop_r, stop_c) if given.
  task automatic run_frame(input bit gaps, input bit first_sof, input int stop_r, input int stop_c);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++) begin
        if (r == stop_r && c == stop_c) return;
        put(r, c, first_sof && r == 0 && c == 0, gaps);
      end
  endtask

  task automatic mark();
    req(3);
    idle(2);
  endtask

  task automatic expect_counts(input int n, input int f);
    idle(2);
    req_n = n;
    req_f = f;
    req(4);
    idle(2);
  endtask

  initial begin
    n_rst = 1'b0;
    pixel_valid = 1'b0;
    sof = 1'b0;
    pixel_in = 8'h00;
    idle(2);
    n_rst = 1'b1;
    req(5);
    idle(2);

    // Continuous frame starting with sof.
    mark();
    run_frame(1'b0, 1'b1, -1, -1);
    expect_counts(4, 1);

    // Same frame with random valid gaps.
    mark();
    run_frame(1'b1, 1'b0, -1, -1);
    expect_counts(4, 1);

    // Two frames back-to-back relying on the implicit wrap.
    mark();
    run_frame(1'b0, 1'b0, -1, -1);
    run_frame(1'b0, 1'b0, -1, -1);
    expect_counts(8, 2);

    // sof at (2,1) abandons the frame; full frame follows.
    mark();
    run_frame(1'b0, 1'b0, 2, 1);
    run_frame(1'b0, 1'b1, -1, -1);
    expect_counts(4, 1);

    // Reset after (2,3), with an accept attempted in the reset cycle.
    mark();
    run_frame(1'b0, 1'b0, 3, 0);
    @(negedge clk); #1;
    n_rst = 1'b0;
    pixel_valid = 1'b1;
    pixel_in = 8'hAA;
    @(negedge clk); #1;
    n_rst = 1'b1;
    pixel_valid = 1'b0;
    req(5);
    expect_counts(2, 0);
    mark();
    run_frame(1'b0, 1'b0, -1, -1);
    expect_counts(4, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

- Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel gradient stages.
- Accepts one 8-bit grayscale pixel per valid cycle in raster order and keeps the two previous image rows in internal line buffers.
- Presents the 3x3 window P0..P8 plus a one-cycle start_calculations strobe whenever a complete window exists.
- P0..P8 and start_calculations feed the horizontal and vertical gradient blocks unchanged.

## Interface
- IMG_WIDTH, 640, pixels per row (>= 3)
- IMG_HEIGHT, 480, rows per frame (>= 3)
- clk  input  1  rising-edge clock
- n_rst  input  1  reset, synchronous, active-low
- pixel_in  input  8  incoming grayscale pixel
- pixel_valid  input  1  pixel_in is accepted this cycle
- sof  input  1  start of frame; qualified by pixel_valid; marks pixel_in as (row 0, col 0)
- P0..P8  output  8 each  window; P0-P2 row r-2, P3-P5 row r-1, P6-P8 row r; in each row the lowest index is col c-2 and the highest is col c
- start_calculations  output  1  one-cycle strobe: P0..P8 hold a new complete window
- center_row  output  $clog2(IMG_HEIGHT)  row of window centre (r-1)
- center_col  output  $clog2(IMG_WIDTH)  column of window centre (c-1)
- frame_done  output  1  one-cycle strobe after the last pixel of a frame is accepted

## Operation
- Counters row and col give the position of the next accepted pixel. Reset value is 0/0.
- Accept occurs when pixel_valid=1. On a cycle with pixel_valid=0, nothing changes and the outputs hold their values.
- If sof=1 on an accept, the pixel is treated as (0,0) regardless of the counters. The counters then advance to (0,1).
- Counter advance:
  - col increments each accept.
  - At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 (implicit new frame).
- Line buffers lb1 (row r-1) and lb0 (row r-2), IMG_WIDTH x 8 each, are indexed by col. On accept at column c:
  - top = lb0[c], mid = lb1[c], bot = pixel_in.
  - lb0[c] <= lb1[c], lb1[c] <= pixel_in.
- Window shift on accept:
  - P0<=P1, P1<=P2, P2<=top.
  - P3<=P4, P4<=P5, P5<=mid.
  - P6<=P7, P7<=P8, P8<=bot.
- Window validity:
  - start_calculations <= 1 iff the accepted pixel has row>=2 and col>=2 (sof pixels count as row 0).
  - Otherwise start_calculations <= 0.
  - center_row <= row-1 and center_col <= col-1 are loaded whenever start_calculations is set. They hold otherwise.
- Windows spanning a row boundary (col 0, 1) and rows 0-1 are never flagged. Stale line-buffer or window contents are therefore never consumed.
- frame_done <= 1 for one cycle after the accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per uninterrupted frame.
- Pixel values pass through unmodified. No arithmetic beyond the counters.

## Timing
- Reset (n_rst=0 at a clk edge):
  - row, col, P0..P8, center_row, center_col = 0.
  - start_calculations = 0, frame_done = 0.
  - Line buffer contents are not reset (don't-care). Reset overrides an accept in the same cycle.
- Latency:
  - The window containing pixel (r,c) is on P0..P8, with start_calculations=1, in the cycle after that pixel is accepted.
  - start_calculations is high for exactly one cycle per flagged accept.
- Back-to-back accepts give back-to-back strobes. Gaps in pixel_valid create equal gaps in the strobes, with no loss or duplication.
- sof mid-frame: the partial frame is abandoned and the new frame restarts at (0,0). No window is flagged until the new frame's (2,2).
- Reset mid-frame: identical to sof on the next accepted pixel.
- Simultaneous sof and frame-wrap: sof wins, and the pixel is (0,0). frame_done fires only for a natural last-pixel accept, not for sof.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=4, pixel=16*row+col, continuous valid, then accept (2,2):
  - Next cycle: P0..P8 = 00,01,02,10,11,12,20,21,22, start_calculations=1, center=(1,1).
- Same frame end to end:
  - Exactly 4 strobes, at accepts (2,2),(2,3),(3,2),(3,3).
  - frame_done pulses once, one cycle after (3,3).
  - The last window is P0..P8 = 11,12,13,21,22,23,31,32,33.
- Random pixel_valid gaps (about 50%) on the same frame:
  - Identical window sequence and values.
  - Outputs hold during gaps, with no extra strobes.
- Two frames back-to-back without sof:
  - The second frame yields the same 4 windows.
  - No strobe at the second frame's rows 0-1 or at cols 0-1 of any row.
- sof asserted at (2,1) of frame 1, then a full frame:
  - No strobe until the new (2,2), then 4 correct windows.
- n_rst=0 for one cycle after (2,3), then a full frame:
  - All outputs read 0 the cycle after reset.
  - The restarted frame gives 4 correct windows.
